stream_demultiplexer: RTL and testbench
=======================================

# stream_demultiplexer

Registered, flow-controlled demultiplexer: routes each word of one valid/ready input stream to one of 2**SELECT_WIDTH output channels, or to all of them in broadcast mode. Each channel has a one-entry output register, so a stalled consumer blocks only traffic addressed to it. It replaces the combinational demultiplexer wherever datapath results are steered to consumers that can back-pressure, such as register-file write ports and memory/IO units.

## Interface
- WIDTH, 16: data word width in bits.
- SELECT_WIDTH, 2: index width; channel count N = 2**SELECT_WIDTH.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word on data_in.
- in_ready  output  1  the word on data_in is accepted this cycle.
- data_in  input  WIDTH  word to route.
- index  input  SELECT_WIDTH  destination channel; ignored when broadcast=1.
- broadcast  input  1  route the word to all N channels.
- out_valid  output  N  per-channel slot holds a word.
- out_ready  input  N  per-channel consumer accepts the word.
- data_out  output  WIDTH x N (unpacked [N])  per-channel word; '0 when that channel's out_valid is 0.

## Operation
- Per channel i: a slot with valid_q[i] and data_q[i]. out_valid[i] = valid_q[i]. data_out[i] = valid_q[i] ? data_q[i] : '0.
- Channel i can load when free_i = !valid_q[i] || out_ready[i].
- Target set T: all channels if broadcast=1, else only channel index.
- in_ready = AND of free_i over T. This is combinational from valid_q, out_ready, index and broadcast. It does not depend on in_valid.
- Accept = in_valid && in_ready. On accept, every channel in T loads data_in and sets valid_q.
- Per channel, when it is not loaded and out_ready[i] && valid_q[i], the channel clears valid_q[i]. data_q[i] holds its value.
- Broadcast is all-or-nothing. If any channel is stalled (valid_q=1, out_ready=0), no channel loads and in_ready=0.
- Simultaneous drain and load on one channel: the new word replaces the old one and valid stays 1. No bubble.
- out_ready[i] while valid_q[i]=0 has no effect.
- Producer rule: in_valid, data_in, index and broadcast must stay stable while in_valid=1 && in_ready=0.
- Consumer rule: data_out[i] is stable while out_valid[i]=1 && out_ready[i]=0.
- No word is ever dropped or duplicated to a non-target channel.

## Timing
- Reset (synchronous, takes priority over accept): valid_q='0, data_q='0. Consequently out_valid='0, data_out all '0. in_ready is then 1 for any target set.
- Reset mid-operation discards all pending words. An accept in the reset cycle is lost.
- Latency: accepted at edge k, so out_valid/data_out is visible after edge k, i.e. in cycle k+1.
- Throughput: 1 word/cycle per channel with out_ready held high. Words to different channels are also 1/cycle.
- in_ready combinationally depends on out_ready. A producer must not drive in_valid from in_ready.
- index wrap: every SELECT_WIDTH value is a legal channel. No out-of-range case exists.

## Structure
- Package demux_pkg: localparam function num_channels(SELECT_WIDTH) = 2**SELECT_WIDTH; typedef of the per-channel slot struct {logic valid; logic [WIDTH-1:0] data}. Use a parameterised-class or type parameter if the width must be generic.
- Sub-module demux_channel_slot: one slot. Ports: clk, reset, load, data_in, out_ready, out_valid, data_out, free. Instantiate it N times in a generate loop.
- Top level: the target-decode logic (index compare or broadcast) and the in_ready AND-reduction.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1. Required: out_valid=0000, all data_out=0, no load. After release, in_ready=1.
- Single route: WIDTH=16, data_in=0xBEEF, index=2, out_ready=1111. Required: next cycle out_valid=0100, data_out[2]=0xBEEF, others 0. One cycle later out_valid=0000.
- Back-pressure: fill channel 1 with 0x0011 while out_ready[1]=0, then offer 0x0022 to channel 1. Required: in_ready=0, data_out[1] stays 0x0011. Offering 0x0033 to channel 3 is accepted meanwhile. Raising out_ready[1] accepts 0x0022 in the same cycle, with no bubble.
- Broadcast: broadcast=1, data_in=0x1234. With all out_ready=1, all four channels show 0x1234 next cycle. Repeat with channel 0 stalled holding 0x0001: in_ready=0, and channels 1-3 stay unloaded until out_ready[0]=1.
- Streaming: 32 back-to-back words with index cycling 0..3 and all out_ready=1. Required: one accept per cycle and each channel receives its 8 words in order.
- Reset mid-stream: assert reset while channels 0 and 2 are valid and stalled. Required: out_valid=0000 after the edge, and the stalled words never appear.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared channel-count helper and slot record for the stream demultiplexer
package demux_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef struct packed {
        logic                     valid;
        logic [DEFAULT_WIDTH-1:0] data;
    } slot_t;

    function automatic int num_channels(input int select_width);
        return 2 ** select_width;
    endfunction

endpackage

// File: rtl/demux_channel_slot.sv
// demux_channel_slot: one-entry output register for a single demultiplexer channel
module demux_channel_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             free
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } slot_t;

    slot_t q;

    // load wins over drain so a simultaneous drain+load keeps the slot full with the new word
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else if (load) q <= '{valid: 1'b1, data: data_in};
        else if (out_ready) q.valid <= 1'b0;
    end

    assign free      = !q.valid || out_ready;
    assign out_valid = q.valid;
    assign data_out  = q.valid ? q.data : '0;

endmodule

// File: rtl/stream_demultiplexer.sv
// stream_demultiplexer: routes a valid/ready stream to one or all registered output channels
module stream_demultiplexer
    import demux_pkg::*;
#(
    parameter int  WIDTH        = DEFAULT_WIDTH,
    parameter int  SELECT_WIDTH = 2,
    localparam int N            = num_channels(SELECT_WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        data_in,
    input  logic [SELECT_WIDTH-1:0] index,
    input  logic                    broadcast,
    output logic [N-1:0]            out_valid,
    input  logic [N-1:0]            out_ready,
    output logic [WIDTH-1:0]        data_out [N]
);

    logic [N-1:0] target;
    logic [N-1:0] free;
    logic [N-1:0] load;

    // every targeted channel must be able to take the word, so broadcast is all-or-nothing
    assign in_ready = &(free | ~target);

    for (genvar i = 0; i < N; i++) begin : g_ch
        assign target[i] = broadcast || (index == SELECT_WIDTH'(i));
        assign load[i]   = in_valid && in_ready && target[i];
        demux_channel_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (load[i]),
            .data_in   (data_in),
            .out_ready (out_ready[i]),
            .out_valid (out_valid[i]),
            .data_out  (data_out[i]),
            .free      (free[i])
        );
    end

endmodule

// File: tb/tb_stream_demultiplexer.sv
// tb_stream_demultiplexer: directed and random checks against a per-channel queue model
module tb_stream_demultiplexer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_in;
    logic [1:0]  index;
    logic        broadcast;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] data_out [4];

    int errors = 0;
    int checks = 0;
    logic hold = 1'b0;
    logic [15:0] pend [4][$];

    stream_demultiplexer #(.WIDTH(16), .SELECT_WIDTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .index     (index),
        .broadcast (broadcast),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [15:0] d, input int idx, input logic bc, input logic [3:0] ordy);
        in_valid  = 1'b1;
        data_in   = d;
        index     = 2'(idx);
        broadcast = bc;
        out_ready = ordy;
        #1;
    endtask

    task automatic idle(input logic [3:0] ordy);
        in_valid  = 1'b0;
        out_ready = ordy;
        #1;
    endtask

    // compare DUT against the queue model, then advance one clock and update the model
    task automatic cycle();
        logic er;
        er = 1'b1;
        #1;
        for (int c = 0; c < 4; c++)
            if ((broadcast || index == c) && pend[c].size() != 0 && !out_ready[c]) er = 1'b0;
        check("in_ready", {31'b0, in_ready}, {31'b0, er});
        for (int c = 0; c < 4; c++) begin
            check($sformatf("out_valid%0d", c), {31'b0, out_valid[c]}, {31'b0, pend[c].size() != 0});
            check($sformatf("data_out%0d", c), {16'b0, data_out[c]},
                  {16'b0, pend[c].size() != 0 ? pend[c][0] : 16'h0});
        end
        hold = in_valid && !er;
        @(posedge clk);
        for (int c = 0; c < 4; c++) begin
            if (reset) pend[c].delete();
            else begin
                if (out_ready[c] && pend[c].size() != 0) void'(pend[c].pop_front());
                if (in_valid && er && (broadcast || index == c)) pend[c].push_back(data_in);
            end
        end
        #1;
    endtask

    initial begin
        int acc;
        reset = 1'b1;
        drive(16'hDEAD, 1, 1'b0, 4'b0000);
        @(posedge clk);
        #1;
        cycle();
        check("rst_out_valid", {28'b0, out_valid}, 32'h0);
        reset = 1'b0;
        idle(4'b1111);
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);

        drive(16'hBEEF, 2, 1'b0, 4'b1111);
        cycle();
        idle(4'b1111);
        check("single_valid", {28'b0, out_valid}, 32'h4);
        check("single_d2", {16'b0, data_out[2]}, 32'hBEEF);
        check("single_d0", {16'b0, data_out[0]}, 32'h0);
        cycle();
        check("single_gone", {28'b0, out_valid}, 32'h0);

        drive(16'h0011, 1, 1'b0, 4'b1101);
        cycle();
        drive(16'h0022, 1, 1'b0, 4'b1101);
        check("bp_ready", {31'b0, in_ready}, 32'h0);
        cycle();
        check("bp_hold", {16'b0, data_out[1]}, 32'h0011);
        drive(16'h0033, 3, 1'b0, 4'b1101);
        check("bp_other_ready", {31'b0, in_ready}, 32'h1);
        cycle();
        check("bp_d3", {16'b0, data_out[3]}, 32'h0033);
        drive(16'h0022, 1, 1'b0, 4'b1111);
        check("bp_release_ready", {31'b0, in_ready}, 32'h1);
        cycle();
        check("bp_nobubble_v", {31'b0, out_valid[1]}, 32'h1);
        check("bp_nobubble_d", {16'b0, data_out[1]}, 32'h0022);

        idle(4'b1111);
        cycle();
        drive(16'h1234, 0, 1'b1, 4'b1111);
        cycle();
        idle(4'b1111);
        check("bc_valid", {28'b0, out_valid}, 32'hF);
        for (int c = 0; c < 4; c++) check("bc_data", {16'b0, data_out[c]}, 32'h1234);
        cycle();
        drive(16'h0001, 0, 1'b0, 4'b1110);
        cycle();
        drive(16'h1234, 0, 1'b1, 4'b1110);
        check("bc_stall_ready", {31'b0, in_ready}, 32'h0);
        cycle();
        check("bc_stall_valid", {28'b0, out_valid}, 32'h1);
        check("bc_stall_d0", {16'b0, data_out[0]}, 32'h0001);
        drive(16'h1234, 0, 1'b1, 4'b1111);
        check("bc_release_ready", {31'b0, in_ready}, 32'h1);
        cycle();
        check("bc_release_valid", {28'b0, out_valid}, 32'hF);
        for (int c = 0; c < 4; c++) check("bc_release_data", {16'b0, data_out[c]}, 32'h1234);

        acc = 0;
        for (int i = 0; i < 32; i++) begin
            drive(16'h0100 + 16'(i), i % 4, 1'b0, 4'b1111);
            if (in_ready) acc++;
            cycle();
        end
        check("stream_accepts", acc, 32);

        idle(4'b1111);
        cycle();
        drive(16'hAAAA, 0, 1'b0, 4'b1010);
        cycle();
        drive(16'hBBBB, 2, 1'b0, 4'b1010);
        cycle();
        check("mid_pre_valid", {28'b0, out_valid}, 32'h5);
        reset = 1'b1;
        drive(16'hCCCC, 1, 1'b0, 4'b1010);
        cycle();
        reset = 1'b0;
        idle(4'b1111);
        check("mid_rst_valid", {28'b0, out_valid}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("mid_never", {28'b0, out_valid}, 32'h0);
        end

        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                in_valid  = ($urandom_range(3) != 0);
                data_in   = 16'($urandom);
                index     = 2'($urandom_range(3));
                broadcast = ($urandom_range(7) == 0);
            end
            out_ready = 4'($urandom);
            #1;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
